// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared widths, FSM state type and saturating add for the gyro integrator
package gyro_pkg;
  localparam int RATE_W   = 16;
  localparam int ANGLE_W  = 32;
  localparam int NUM_AXES = 3;

  typedef enum logic [0:0] {CAL = 1'b0, RUN = 1'b1} state_t;

  // 33-bit sum of accumulator and 17-bit delta; a sign disagreement
  // between the top two bits means the 32-bit result would wrap.
  function automatic logic signed [ANGLE_W-1:0] sat_add32(
    input logic signed [ANGLE_W-1:0] acc,
    input logic signed [RATE_W:0]    delta
  );
    logic signed [ANGLE_W:0] sum;
    sum = {acc[ANGLE_W-1], acc} + {{(ANGLE_W-RATE_W){delta[RATE_W]}}, delta};
    if (sum[ANGLE_W] != sum[ANGLE_W-1])
      sat_add32 = sum[ANGLE_W] ? {1'b1, {(ANGLE_W-1){1'b0}}} : {1'b0, {(ANGLE_W-1){1'b1}}};
    else
      sat_add32 = sum[ANGLE_W-1:0];
  endfunction
endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running divider producing a one-cycle sample tick every DIV clocks
module sample_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic RST,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  if (DIV < 8) begin : g_div_check
    $error("sample_tick_gen: DIV must be at least 8");
  end

  always_ff @(posedge clk) begin
    if (RST)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/gyro_integrator.sv
// rtl/gyro_integrator.sv - bias-calibrated, saturating three-axis rate integrator
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 100,
  parameter int CAL_LOG2  = 6
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic signed [RATE_W-1:0]  x_axis_data,
  input  logic signed [RATE_W-1:0]  y_axis_data,
  input  logic signed [RATE_W-1:0]  z_axis_data,
  input  logic                      clear,
  input  logic                      recal,
  output logic signed [ANGLE_W-1:0] x_angle,
  output logic signed [ANGLE_W-1:0] y_angle,
  output logic signed [ANGLE_W-1:0] z_angle,
  output logic                      calibrated,
  output logic                      sample_valid
);
  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int SUM_W = RATE_W + CAL_LOG2;

  logic                     tick;
  state_t                   state;
  logic signed [RATE_W-1:0] snap [NUM_AXES];
  logic signed [RATE_W-1:0] bias [NUM_AXES];
  logic signed [SUM_W-1:0]  sum  [NUM_AXES];
  logic [CAL_LOG2-1:0]      cal_count;
  logic                     busy;
  logic [1:0]               axis;

  logic signed [RATE_W-1:0]  snap_sel, bias_sel;
  logic signed [SUM_W-1:0]   sum_sel, sum_next, sum_shr;
  logic signed [ANGLE_W-1:0] angle_sel, angle_next;
  logic signed [RATE_W:0]    delta;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .RST  (RST),
    .tick (tick)
  );

  // One axis per cycle goes through the shared adder, selected by the sequencer index.
  always_comb begin
    snap_sel  = snap[2];
    bias_sel  = bias[2];
    sum_sel   = sum[2];
    angle_sel = z_angle;
    case (axis)
      2'd0: begin
        snap_sel  = snap[0];
        bias_sel  = bias[0];
        sum_sel   = sum[0];
        angle_sel = x_angle;
      end
      2'd1: begin
        snap_sel  = snap[1];
        bias_sel  = bias[1];
        sum_sel   = sum[1];
        angle_sel = y_angle;
      end
      default: ;
    endcase
  end

  assign delta      = {snap_sel[RATE_W-1], snap_sel} - {bias_sel[RATE_W-1], bias_sel};
  assign angle_next = sat_add32(angle_sel, delta);
  assign sum_next   = sum_sel + {{CAL_LOG2{snap_sel[RATE_W-1]}}, snap_sel};
  assign sum_shr    = sum_next >>> CAL_LOG2;
  assign calibrated = (state == RUN);

  always_ff @(posedge clk) begin
    sample_valid <= 1'b0;
    if (RST || recal) begin
      state     <= CAL;
      busy      <= 1'b0;
      axis      <= 2'd0;
      cal_count <= '0;
      x_angle   <= '0;
      y_angle   <= '0;
      z_angle   <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        sum[i]  <= '0;
        bias[i] <= '0;
        snap[i] <= '0;
      end
    end else if (clear) begin
      busy    <= 1'b0;
      axis    <= 2'd0;
      x_angle <= '0;
      y_angle <= '0;
      z_angle <= '0;
    end else if (tick) begin
      snap[0] <= x_axis_data;
      snap[1] <= y_axis_data;
      snap[2] <= z_axis_data;
      busy    <= 1'b1;
      axis    <= 2'd0;
    end else if (busy) begin
      axis <= axis + 2'd1;
      if (axis == 2'd2)
        busy <= 1'b0;
      if (state == RUN) begin
        case (axis)
          2'd0:    x_angle <= angle_next;
          2'd1:    y_angle <= angle_next;
          default: z_angle <= angle_next;
        endcase
        if (axis == 2'd2)
          sample_valid <= 1'b1;
      end else begin
        // On the final calibration sample each axis latches its bias from the completed sum.
        for (int i = 0; i < NUM_AXES; i++) begin
          if (axis == 2'(i)) begin
            sum[i] <= sum_next;
            if (&cal_count)
              bias[i] <= sum_shr[RATE_W-1:0];
          end
        end
        if (axis == 2'd2) begin
          cal_count <= cal_count + CAL_LOG2'(1);
          if (&cal_count)
            state <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_gyro_integrator.sv
// tb/tb_gyro_integrator.sv - directed self-checking bench for gyro_integrator
module tb_gyro_integrator;
  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic               clear = 1'b0, recal = 1'b0;
  logic signed [31:0] x_angle, y_angle, z_angle;
  logic               calibrated, sample_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [31:0] xa_t [1:4];
  logic signed [31:0] ya_t [1:4];
  logic signed [31:0] za_t [1:4];
  logic               sv_t [1:4];
  logic               cal_t [1:4];

  gyro_integrator #(.CLK_HZ(1000), .SAMPLE_HZ(100), .CAL_LOG2(2)) dut (
    .clk          (clk),
    .RST          (RST),
    .x_axis_data  (x_in),
    .y_axis_data  (y_in),
    .z_axis_data  (z_in),
    .clear        (clear),
    .recal        (recal),
    .x_angle      (x_angle),
    .y_angle      (y_angle),
    .z_angle      (z_angle),
    .calibrated   (calibrated),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the tick cycle T.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dut.tick && n < 40);
    if (!dut.tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: observed no tick expected tick within 40 cycles");
    end
  endtask

  // Drives one rate vector, waits for its tick T and records outputs in T+1..T+4.
  task automatic do_sample(input int xv, input int yv, input int zv);
    x_in = 16'(xv);
    y_in = 16'(yv);
    z_in = 16'(zv);
    wait_tick();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      xa_t[k]  = x_angle;
      ya_t[k]  = y_angle;
      za_t[k]  = z_angle;
      sv_t[k]  = sample_valid;
      cal_t[k] = calibrated;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_x", x_angle, 0);
    check("rst_y", y_angle, 0);
    check("rst_z", z_angle, 0);
    check_bit("rst_cal", calibrated, 1'b0);
    check_bit("rst_sv", sample_valid, 1'b0);
    RST = 1'b0;

    // Bias averaging: x -> 7>>>2 = 1, y -> -7>>>2 = -2, z -> 0
    do_sample(1, -1, 0);
    do_sample(2, -2, 0);
    do_sample(2, -2, 0);
    check_bit("cal_not_yet", cal_t[4], 1'b0);
    do_sample(2, -2, 0);
    check_bit("cal_t3", cal_t[3], 1'b0);
    check_bit("cal_t4", cal_t[4], 1'b1);
    check_bit("cal_no_sv", sv_t[4], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      do_sample(1, -2, 5);
      check_bit("avg_sv", sv_t[4], 1'b1);
      check("avg_z", za_t[4], 32'(5 * k));
    end
    check("avg_x", xa_t[4], 0);
    check("avg_y", ya_t[4], 0);

    // Integration with bias (100, -50, 0)
    recal = 1'b1;
    repeat (2) @(negedge clk);
    recal = 1'b0;
    check_bit("recal_cal", calibrated, 1'b0);
    check("recal_z", z_angle, 0);
    repeat (4) do_sample(100, -50, 0);
    check_bit("int_cal", cal_t[4], 1'b1);
    for (int k = 1; k <= 5; k++) begin
      do_sample(110, -60, 7);
      if (k == 1) begin
        check("seq_x_t2", xa_t[2], 10);
        check("seq_y_t2", ya_t[2], 0);
        check("seq_y_t3", ya_t[3], -10);
        check("seq_z_t3", za_t[3], 0);
      end
      check_bit("int_sv_t3", sv_t[3], 1'b0);
      check_bit("int_sv_t4", sv_t[4], 1'b1);
      check("int_x", xa_t[4], 32'(10 * k));
      check("int_y", ya_t[4], -32'(10 * k));
      check("int_z", za_t[4], 32'(7 * k));
    end

    // Clear in T+2 of a RUN sample
    x_in = 16'sd110; y_in = -16'sd60; z_in = 16'sd7;
    wait_tick();
    repeat (2) @(negedge clk);
    check("clr_x_pre", x_angle, 60);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_x", x_angle, 0);
    check("clr_y", y_angle, 0);
    check("clr_z", z_angle, 0);
    check_bit("clr_cal", calibrated, 1'b1);
    @(negedge clk);
    check_bit("clr_no_sv", sample_valid, 1'b0);
    do_sample(110, -60, 7);
    check("clr_next_x", xa_t[4], 10);
    check("clr_next_y", ya_t[4], -10);
    check("clr_next_z", za_t[4], 7);

    // Positive saturation
    force dut.z_angle = 32'sd2147443648;
    @(negedge clk);
    release dut.z_angle;
    do_sample(100, -50, 32767);
    check("sat_p1", za_t[4], 32'sd2147476415);
    do_sample(100, -50, 32767);
    check("sat_p2", za_t[4], 32'sh7FFF_FFFF);
    do_sample(100, -50, 32767);
    check("sat_p3", za_t[4], 32'sh7FFF_FFFF);
    check("sat_x", xa_t[4], 10);

    // Negative saturation
    force dut.z_angle = -32'sd2147443648;
    @(negedge clk);
    release dut.z_angle;
    do_sample(100, -50, -32768);
    check("sat_n1", za_t[4], -32'sd2147476416);
    do_sample(100, -50, -32768);
    check("sat_n2", za_t[4], 32'sh8000_0000);
    do_sample(100, -50, -32768);
    check("sat_n3", za_t[4], 32'sh8000_0000);

    // RST pulse mid-run
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("rst2_x", x_angle, 0);
    check("rst2_z", z_angle, 0);
    check_bit("rst2_cal", calibrated, 1'b0);
    check_bit("rst2_sv", sample_valid, 1'b0);
    repeat (3) do_sample(3, 3, 3);
    check_bit("rst2_cal3", cal_t[4], 1'b0);
    do_sample(3, 3, 3);
    check_bit("rst2_cal4", cal_t[4], 1'b1);
    do_sample(4, 4, 4);
    check("rst2_x1", xa_t[4], 1);
    check("rst2_y1", ya_t[4], 1);

    // recal and clear together
    recal = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    clear = 1'b0;
    check_bit("rc_cal", calibrated, 1'b0);
    check("rc_x", x_angle, 0);
    check("rc_y", y_angle, 0);
    repeat (3) do_sample(-5, 8, 0);
    check_bit("rc_cal3", cal_t[4], 1'b0);
    do_sample(-5, 8, 0);
    check_bit("rc_cal4", cal_t[4], 1'b1);
    do_sample(-4, 8, 2);
    check("rc_new_x", xa_t[4], 1);
    check("rc_new_y", ya_t[4], 0);
    check("rc_new_z", za_t[4], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
